// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory, ALU and branch steps.
// The state is registered; controls are decoded from it and forced idle while rst_n is low.
module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       retired,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t r_state;
    state_t w_next;
    logic   w_legal;

    assign w_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                     (opcode == OP_I) || (opcode == OP_BEQ) || (opcode == OP_JAL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Controls are combinational from the registered state so the first fetch is visible as soon as reset lifts.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        retired       = 1'b0;
        illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                retired   = !TRAP_ON_ILLEGAL && !w_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retired    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                retired   = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
                retired   = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_TRAP:  illegal_instr = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            retired       = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: random instruction streams walked against
// per-class state paths, plus directed trap, stall and reset scenarios on two parameterisations.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1, retired1, illegal1;
    logic [1:0] a1, b1, op1, rs1, imm1;
    logic [3:0] st1;
    logic       mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0, retired0, illegal0;
    logic [1:0] a0, b0, op0, rs0, imm0;
    logic [3:0] st0;

    logic [15:0] v1, v0;
    assign v1 = {mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1,
                 a1, b1, op1, rs1, retired1, illegal1};
    assign v0 = {mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0,
                 a0, b0, op0, rs0, retired0, illegal0};

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                           II = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                           BAD = 7'b1111111;
    localparam logic [15:0] RESET_VEC = 16'h0088; // b=10, result_src=10, everything else 0

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req1), .mem_write(mem_write1), .adr_src(adr_src1), .ir_write(ir_write1),
        .pc_write(pc_write1), .reg_write(reg_write1), .alu_src_a(a1), .alu_src_b(b1),
        .alu_op(op1), .result_src(rs1), .imm_src(imm1), .retired(retired1),
        .illegal_instr(illegal1), .state(st1));

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .mem_write(mem_write0), .adr_src(adr_src0), .ir_write(ir_write0),
        .pc_write(pc_write0), .reg_write(reg_write0), .alu_src_a(a0), .alu_src_b(b0),
        .alu_op(op0), .result_src(rs0), .imm_src(imm0), .retired(retired0),
        .illegal_instr(illegal0), .state(st0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control vector each state must show, written straight from the state descriptions.
    function automatic logic [15:0] exp_vec(input int st, input logic mr, input logic z,
                                            input logic ret_dec);
        logic mreq, mw, adr, irw, pcw, rw, ret, ill;
        logic [1:0] a, b, op, rs;
        {mreq, mw, adr, irw, pcw, rw, ret, ill} = '0;
        {a, b, op, rs} = '0;
        case (st)
            0:  begin mreq = 1; b = 2; rs = 2; irw = mr; pcw = mr; end
            1:  begin a = 1; b = 1; ret = ret_dec; end
            2:  begin a = 2; b = 1; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 1; rw = 1; ret = 1; end
            5:  begin mreq = 1; mw = 1; adr = 1; ret = mr; end
            6:  begin a = 2; op = 2; end
            7:  begin a = 2; b = 1; op = 2; end
            8:  begin rw = 1; ret = 1; end
            9:  begin a = 2; op = 1; pcw = z; ret = 1; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: ill = 1;
            default: ;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, a, b, op, rs, ret, ill};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Walk one legal instruction through its state path; stall is the number of not-ready
    // cycles in the data-memory state (negative = random).
    task automatic run_instr(input logic [6:0] op, input int stall);
        int path[$];
        int idx = 0, waited = 0, cyc = 0, ret_cnt = 0, st;
        logic mr;
        case (op)
            LW: path = '{0, 1, 2, 3, 4};
            SW: path = '{0, 1, 2, 5};
            RR: path = '{0, 1, 6, 8};
            II: path = '{0, 1, 7, 8};
            BQ: path = '{0, 1, 9};
            default: path = '{0, 1, 10, 8};
        endcase
        while (idx < path.size()) begin
            @(negedge clk);
            st = path[idx];
            opcode = op;
            zero = 1'($urandom_range(0, 1));
            if ((st == 3 || st == 5) && stall >= 0) mr = (waited >= stall);
            else mr = ($urandom_range(0, 2) != 0) || (waited >= 5);
            mem_ready = mr;
            #1;
            check("state_t1", 32'(st1), 32'(st));
            check("state_t0", 32'(st0), 32'(st));
            check("ctl_t1", 32'(v1), 32'(exp_vec(st, mr, zero, 1'b0)));
            check("ctl_t0", 32'(v0), 32'(exp_vec(st, mr, zero, 1'b0)));
            check("imm_src", 32'(imm1), 32'(exp_imm(op)));
            ret_cnt += int'(retired1);
            if ((st == 0 || st == 3 || st == 5) && !mr) waited++;
            else begin
                idx++;
                waited = 0;
            end
            cyc++;
            if (cyc > 100) begin
                check("timeout", 32'(cyc), 32'd100);
                break;
            end
        end
        check("retired_cnt", 32'(ret_cnt), 32'd1);
    endtask

    initial begin
        logic [6:0] ops[6];
        ops = '{LW, SW, RR, II, BQ, JL};
        rst_n = 1'b0;
        opcode = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("rst_state", 32'(st1), 32'd0);
        check("rst_ctl", 32'(v1), 32'(RESET_VEC));
        check("rst_ctl0", 32'(v0), 32'(RESET_VEC));

        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("first_fetch", 32'(v1), 32'(exp_vec(0, 1'b0, 1'b0, 1'b0)));

        run_instr(LW, 0);
        run_instr(SW, 0);
        run_instr(SW, 3);
        run_instr(RR, 0);
        run_instr(II, 0);
        run_instr(BQ, 0);
        run_instr(BQ, 0);
        run_instr(JL, 0);
        run_instr(LW, 4);
        for (int i = 0; i < 80; i++) run_instr(ops[$urandom_range(0, 5)], -1);

        // Illegal opcode: trapping instance sticks in TRAP, the other retires it as a NOP.
        @(negedge clk);
        opcode = BAD;
        mem_ready = 1'b1;
        #1;
        check("ill_fetch", 32'(st1), 32'd0);
        @(negedge clk);
        #1;
        check("ill_dec_t1", 32'(v1), 32'(exp_vec(1, 1'b1, zero, 1'b0)));
        check("ill_dec_t0", 32'(v0), 32'(exp_vec(1, 1'b1, zero, 1'b1)));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap_state", 32'(st1), 32'd11);
            check("trap_ctl", 32'(v1), 32'(exp_vec(11, mem_ready, zero, 1'b0)));
            if (i == 0) check("nop_back_fetch", 32'(st0), 32'd0);
        end

        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("trap_rst_state", 32'(st1), 32'd0);
        check("trap_rst_ctl", 32'(v1), 32'(RESET_VEC));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        opcode = LW;
        #1;
        check("refetch", 32'(v1), 32'(exp_vec(0, 1'b0, 1'b0, 1'b0)));

        // Reset arriving mid-way through a MEMREAD stall.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i != 3);
            #1;
        end
        check("memread_stall", 32'(st1), 32'd3);
        check("memread_ctl", 32'(v1), 32'(exp_vec(3, 1'b0, zero, 1'b0)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(st1), 32'd0);
        check("async_rst_state0", 32'(st0), 32'd0);
        check("async_rst_ctl", 32'(v1), 32'(RESET_VEC));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("resume_fetch", 32'(v1), 32'(exp_vec(0, 1'b0, 1'b0, 1'b0)));
        run_instr(LW, 0);
        run_instr(JL, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TRAP_ON_ILLEGAL, default 1: 1 = unsupported opcode enters sticky TRAP; 0 = treated as NOP, return to FETCH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instr[6:0] from instruction register, valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled in BEQ.
REQ-006 mem_ready  input  1  memory completes current request this cycle.
REQ-007 mem_req  output  1  memory request active (FETCH, MEMREAD, MEMWRITE).
REQ-008 mem_write  output  1  write strobe, high throughout MEMWRITE.
REQ-009 adr_src  output  1  0 = PC, 1 = ALUOut as memory address.
REQ-010 ir_write, pc_write, reg_write  output  1 each  IR / PC / register-file write enables.
REQ-011 alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-012 alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-013 alu_op  output  2  00 add, 01 subtract (compare), 10 funct-decoded.
REQ-014 result_src  output  2  00 ALUOut, 01 read data, 10 ALU result.
REQ-015 imm_src  output  2  combinational from opcode: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
REQ-016 retired  output  1  one-cycle pulse in final cycle of each instruction.
REQ-017 illegal_instr  output  1  high while in TRAP.
REQ-018 state  output  4  current state encoding, debug.

Function
REQ-019 States/encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11; 12-15 SHALL go to FETCH.
REQ-020 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; hold until mem_ready, then DECODE.
REQ-021 DECODE: a=01, b=01, alu_op=00; next by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BEQ, 1101111 JAL, other TRAP (or FETCH if TRAP_ON_ILLEGAL=0, with retired=1).
REQ-022 MEMADR: a=10, b=01, alu_op=00; opcode 0000011 to MEMREAD, else MEMWRITE.
REQ-023 MEMREAD: mem_req=1, adr_src=1, result_src=00; hold until mem_ready, then MEMWB.
REQ-024 MEMWB: result_src=01, reg_write=1, retired=1; then FETCH.
REQ-025 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; hold until mem_ready; retired=mem_ready; then FETCH.
REQ-026 EXECR: a=10, b=00, alu_op=10; EXECI: a=10, b=01, alu_op=10; both to ALUWB.
REQ-027 ALUWB: result_src=00, reg_write=1, retired=1; then FETCH.
REQ-028 BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero, retired=1; then FETCH.
REQ-029 JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1; then ALUWB.
REQ-030 TRAP: all enables and mem_req 0, illegal_instr=1; exit only via reset.
REQ-031 Unlisted outputs per state SHALL be 0.
REQ-032 Cycles per instruction with zero-wait memory: lw 5, sw 4, R/I 4, beq 3, jal 4.
REQ-033 mem_write, reg_write, pc_write never assert in the same cycle.

Reset
REQ-034 rst_n low SHALL force state=FETCH immediately, mid-instruction or mid-stall.
REQ-035 While rst_n low, mem_req, mem_write, ir_write, pc_write, reg_write, retired, illegal_instr SHALL be 0; selects take FETCH values.
REQ-036 First fetch request SHALL appear combinationally once rst_n is high.

Verification
REQ-037 lw 0000011, mem_ready=1 always -> states 0,1,2,3,4; reg_write only in state 4 with result_src=01; retired once.
REQ-038 sw, mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 cycles, retired only on ready cycle, no reg_write.
REQ-039 beq with zero=1 then zero=0 -> pc_write 1 then 0 in BEQ; 3-cycle instructions.
REQ-040 jal 1101111 -> 0,1,10,8; pc_write in JAL, reg_write in ALUWB with result_src=00.
REQ-041 opcode 1111111 -> TRAP, illegal_instr=1 held 20 cycles; with TRAP_ON_ILLEGAL=0 -> FETCH, retired pulse.
REQ-042 rst_n asserted in MEMREAD stall -> state=0, all enables 0 same cycle; fetch resumes after release.
